// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants, types and helpers for the multiplexed 4-digit display scanner.
package display_scan_ctrl_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned NIBBLE_W   = 4;

    localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

    typedef enum logic {
        PhBlank,
        PhShow
    } scan_phase_e;

    typedef struct packed {
        logic [NIBBLE_W-1:0]   nibble;
        logic [NUM_DIGITS-1:0] an_n;
        logic                  dp_n;
        logic                  frame_tick;
    } scan_out_t;

    localparam scan_out_t SCAN_OUT_RST = '{
        nibble:     4'h0,
        an_n:       AN_OFF,
        dp_n:       1'b1,
        frame_tick: 1'b0
    };

    function automatic int unsigned cnt_width(input int unsigned div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/display_scan_ctrl_scan_prescaler.sv
// Slot prescaler: counts 0..SCAN_DIV-1 and strobes o_wrap on the last cycle of each slot.
module display_scan_ctrl_scan_prescaler
    import display_scan_ctrl_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned CNT_W    = cnt_width(SCAN_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_wrap
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_end;

    assign w_at_end = (r_cnt == CNT_W'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!i_en || w_at_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_wrap = i_en && w_at_end;

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 4-digit 7-segment scanner with per-frame snapshot and anode dead time.
// Optional leading-zero blanking is built when DISPLAY_SCAN_LZB_EN is defined.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    output logic [3:0]  nibble_out,
    output logic [3:0]  an_n,
    output logic        dp_n,
    output logic        frame_tick
);

    localparam int unsigned CNT_W = cnt_width(SCAN_DIV);

    logic [CNT_W-1:0] w_cnt;
    logic             w_wrap;
    logic [1:0]       r_idx;
    logic [15:0]      r_snap_digits;
    logic [3:0]       r_snap_dp;
    logic             w_load;
    scan_phase_e      w_phase;
    logic [3:0]       w_cur_nibble;
    logic             w_cur_dp;
    logic [3:0]       w_an_sel;
    logic             w_lit;
    scan_out_t        w_out_nxt;
    scan_out_t        r_out;

    display_scan_ctrl_scan_prescaler #(
        .SCAN_DIV (SCAN_DIV),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .i_en   (en),
        .o_cnt  (w_cnt),
        .o_wrap (w_wrap)
    );

    // Snapshot only at the very first cycle of a frame so a frame never tears.
    assign w_load = en && (w_cnt == '0) && (r_idx == 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= 2'd0;
        end else if (!en) begin
            r_idx <= 2'd0;
        end else if (w_wrap) begin
            r_idx <= r_idx + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap_digits <= '0;
            r_snap_dp     <= '0;
        end else if (w_load) begin
            r_snap_digits <= digits_in;
            r_snap_dp     <= dp_in;
        end
    end

    assign w_phase      = (w_cnt < CNT_W'(BLANK_CYCLES)) ? PhBlank : PhShow;
    assign w_cur_nibble = r_snap_digits[{r_idx, 2'b00} +: NIBBLE_W];
    assign w_cur_dp     = r_snap_dp[r_idx];

`ifdef DISPLAY_SCAN_LZB_EN
    logic [3:0] w_hi_zero;
    logic [3:0] w_suppress;

    // w_hi_zero[i]: digit i and every digit above it are zero; digit 0 never qualifies.
    always_comb begin
        w_hi_zero    = '0;
        w_hi_zero[3] = (r_snap_digits[15:12] == 4'h0);
        w_hi_zero[2] = w_hi_zero[3] && (r_snap_digits[11:8] == 4'h0);
        w_hi_zero[1] = w_hi_zero[2] && (r_snap_digits[7:4] == 4'h0);
        w_suppress   = w_hi_zero & ~r_snap_dp;
    end

    assign w_lit = (w_phase == PhShow) && !w_suppress[r_idx];
`else
    assign w_lit = (w_phase == PhShow);
`endif

    always_comb begin
        w_an_sel = AN_OFF;
        unique case (r_idx)
            2'd0: w_an_sel = 4'b1110;
            2'd1: w_an_sel = 4'b1101;
            2'd2: w_an_sel = 4'b1011;
            2'd3: w_an_sel = 4'b0111;
        endcase
    end

    // The nibble tracks the slot even while dark, so the decoder settles before the anode opens.
    always_comb begin
        w_out_nxt            = SCAN_OUT_RST;
        w_out_nxt.nibble     = w_cur_nibble;
        w_out_nxt.frame_tick = w_load;
        if (en && w_lit) begin
            w_out_nxt.an_n = w_an_sel;
            w_out_nxt.dp_n = ~w_cur_dp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= SCAN_OUT_RST;
        end else begin
            r_out <= w_out_nxt;
        end
    end

    assign nibble_out = r_out.nibble;
    assign an_n       = r_out.an_n;
    assign dp_n       = r_out.dp_n;
    assign frame_tick = r_out.frame_tick;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (SCAN_DIV=8, BLANK_CYCLES=2): frame-position model
// plus directed literal checks.
module tb_display_scan_ctrl;

    localparam int unsigned SCAN_DIV     = 8;
    localparam int unsigned BLANK_CYCLES = 2;
    localparam int unsigned FRAME        = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  nibble_out;
    logic [3:0]  an_n;
    logic        dp_n;
    logic        frame_tick;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: position within the frame plus the snapshot it is displaying.
    int          m_pos   = 0;
    logic [15:0] m_snap  = '0;
    logic [3:0]  m_sdp   = '0;
    logic        m_valid = 1'b0;
    logic [3:0]  e_nib;
    logic [3:0]  e_an;
    logic        e_dp;
    logic        e_ft;

`ifdef DISPLAY_SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    display_scan_ctrl #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .nibble_out (nibble_out),
        .an_n       (an_n),
        .dp_n       (dp_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic int slot_of(input int pos);
        return pos / SCAN_DIV;
    endfunction

    function automatic bit suppressed(input int s);
        if (!LZB || s == 0) return 1'b0;
        for (int j = s; j < 4; j++) begin
            if (m_snap[j*4 +: 4] != 4'h0) return 1'b0;
        end
        return !m_sdp[s];
    endfunction

    function automatic bit lit(input int pos);
        return ((pos % SCAN_DIV) >= BLANK_CYCLES) && !suppressed(slot_of(pos));
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pos   <= 0;
            m_snap  <= '0;
            m_sdp   <= '0;
            e_nib   <= 4'h0;
            e_an    <= 4'hF;
            e_dp    <= 1'b1;
            e_ft    <= 1'b0;
            m_valid <= 1'b1;
        end else begin
            e_nib <= m_snap[slot_of(m_pos)*4 +: 4];
            e_an  <= (en && lit(m_pos)) ? 4'(~(4'b0001 << slot_of(m_pos))) : 4'hF;
            e_dp  <= (en && lit(m_pos)) ? ~m_sdp[slot_of(m_pos)] : 1'b1;
            e_ft  <= en && (m_pos == 0);
            if (en && m_pos == 0) begin
                m_snap <= digits_in;
                m_sdp  <= dp_in;
            end
            m_pos <= en ? (m_pos + 1) % FRAME : 0;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_nibble", nibble_out, e_nib);
            check("cyc_an_n", an_n, e_an);
            check("cyc_dp_n", dp_n, e_dp);
            check("cyc_frame_tick", frame_tick, e_ft);
            check("cyc_onehot_an", ($countones(~an_n) <= 1), 1'b1);
        end
    end

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ft();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen) n_pass++;
        else $display("FAIL wait_frame_tick: got no pulse in 40 cycles, expected 1");
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        digits_in = 16'h0000;
        dp_in     = 4'b0000;
        adv(3);
        check("rst_an_n", an_n, 4'hF);
        check("rst_nibble", nibble_out, 4'h0);
        check("rst_dp_n", dp_n, 1'b1);
        check("rst_frame_tick", frame_tick, 1'b0);

        // Basic scan of 1234
        rst       = 1'b0;
        en        = 1'b1;
        digits_in = 16'h1234;
        adv(1);
        check("first_tick", frame_tick, 1'b1);
        adv(1);
        check("tick_one_cycle", frame_tick, 1'b0);
        check("d0_blank_an", an_n, 4'hF);
        check("d0_blank_nib", nibble_out, 4'h4);
        adv(1);
        check("d0_show_an", an_n, 4'b1110);
        check("d0_show_nib", nibble_out, 4'h4);
        adv(8);
        check("d1_show_an", an_n, 4'b1101);
        check("d1_show_nib", nibble_out, 4'h3);
        adv(8);
        check("d2_show_an", an_n, 4'b1011);
        check("d2_show_nib", nibble_out, 4'h2);
        adv(8);
        check("d3_show_an", an_n, 4'b0111);
        check("d3_show_nib", nibble_out, 4'h1);
        adv(6);
        check("tick_32", frame_tick, 1'b1);

        // Anti-tear: change inside the digit-1 slot
        adv(11);
        digits_in = 16'h5678;
        adv(7);
        check("tear_d2_nib", nibble_out, 4'h2);
        adv(8);
        check("tear_d3_nib", nibble_out, 4'h1);
        adv(6);
        check("tear_tick", frame_tick, 1'b1);
        adv(2);
        check("new_d0_an", an_n, 4'b1110);
        check("new_d0_nib", nibble_out, 4'h8);
        adv(8);
        check("new_d1_nib", nibble_out, 4'h7);

        // Decimal point on digit 2
        dp_in = 4'b0100;
        adv(22);
        check("dp_tick", frame_tick, 1'b1);
        adv(10);
        check("dp_d1_off", dp_n, 1'b1);
        adv(7);
        check("dp_d2_blank", dp_n, 1'b1);
        adv(1);
        check("dp_d2_show", dp_n, 1'b0);
        check("dp_d2_an", an_n, 4'b1011);

        // en dropped for 5 cycles inside the digit-2 slot
        adv(1);
        en = 1'b0;
        adv(1);
        check("en_off_an", an_n, 4'hF);
        adv(4);
        en = 1'b1;
        adv(1);
        check("en_back_tick", frame_tick, 1'b1);
        check("en_back_blank0", an_n, 4'hF);
        adv(1);
        check("en_back_blank1", an_n, 4'hF);
        adv(1);
        check("en_back_d0_an", an_n, 4'b1110);
        check("en_back_d0_nib", nibble_out, 4'h8);

        // Reset during SHOW
        adv(1);
        rst = 1'b1;
        adv(1);
        check("midrst_an", an_n, 4'hF);
        check("midrst_nib", nibble_out, 4'h0);
        check("midrst_dp", dp_n, 1'b1);
        rst = 1'b0;
        adv(1);
        check("midrst_tick", frame_tick, 1'b1);
        adv(2);
        check("midrst_d0_an", an_n, 4'b1110);
        check("midrst_d0_nib", nibble_out, 4'h8);

        // Leading zeros: 0042
        digits_in = 16'h0042;
        dp_in     = 4'b0000;
        wait_ft();
        adv(2);
        check("lz_d0_an", an_n, 4'b1110);
        check("lz_d0_nib", nibble_out, 4'h2);
        adv(8);
        check("lz_d1_an", an_n, 4'b1101);
        check("lz_d1_nib", nibble_out, 4'h4);
        adv(8);
        check("lz_d2_an", an_n, LZB ? 4'b1111 : 4'b1011);
        check("lz_d2_nib", nibble_out, 4'h0);
        adv(8);
        check("lz_d3_an", an_n, LZB ? 4'b1111 : 4'b0111);

        // All zero: only digit 0 lights when blanking is built in
        digits_in = 16'h0000;
        wait_ft();
        adv(2);
        check("z_d0_an", an_n, 4'b1110);
        check("z_d0_nib", nibble_out, 4'h0);
        adv(8);
        check("z_d1_an", an_n, LZB ? 4'b1111 : 4'b1101);
        adv(16);
        check("z_d3_an", an_n, LZB ? 4'b1111 : 4'b0111);
        adv(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
